alu_seq_hs: RTL and testbench
=============================

// Module: alu_seq_hs
// PURPOSE
//  Parametrised, registered successor to the 4-bit combinational ALU: same 16-op opcode map.
//  Operands and results move over valid/ready handshakes; every output is registered.
//  Multiply can run iteratively (shift-add) to save area.
//  Sits between the operand-issue stage and the writeback stage of the datapath.
// PARAMETERS
//  WIDTH       8  operand width in bits, >= 2
//  MUL_SERIAL  1  1 = iterative multiply, WIDTH busy cycles; 0 = single-cycle multiply
// PORTS
//  clk        in   1        rising-edge clock
//  rst_n      in   1        asynchronous, active-low reset
//  in_valid   in   1        a, b and opcode are valid
//  in_ready   out  1        block accepts an operation this cycle
//  a          in   WIDTH    operand A, unsigned
//  b          in   WIDTH    operand B, unsigned (also the shift amount)
//  opcode     in   4        operation select, see map below
//  out_valid  out  1        result registers hold a result not yet taken
//  out_ready  in   1        consumer takes the result this cycle
//  res_lo     out  WIDTH    result low word (was x)
//  res_hi     out  WIDTH    result high word (was y)
//  zero       out  1        {res_hi,res_lo} == 0
// BEHAVIOUR
//  Single clock domain. rst_n is asynchronous and active-low.
//  Reset values:
//   - state IDLE; out_valid=0; res_lo=0; res_hi=0; zero=1; multiply counter=0.
//   - in_ready=1 after reset release.
//  Handshakes:
//   - An operation is accepted on an edge where in_valid && in_ready.
//   - A result is taken on an edge where out_valid && out_ready.
//  in_ready = (state==IDLE) || (state==DONE && out_ready).
//   - This allows back-to-back accept and drain in one cycle.
//  Results and out_valid hold stable while out_valid && !out_ready.
//  States:
//   IDLE --accept non-MUL, or MUL with MUL_SERIAL=0--> DONE
//   IDLE --accept MUL, MUL_SERIAL=1--> BUSY (counter loads WIDTH)
//   BUSY: one shift-add step per cycle, counter decrements.
//         Counter reaching 1 on this edge -> DONE.
//   DONE --take with no new accept--> IDLE
//   DONE --take and accept on the same edge--> DONE or BUSY, as from IDLE
//  Latency, counted from the accept edge N:
//   - non-MUL ops: out_valid high after edge N.
//   - serial MUL: out_valid high after edge N+WIDTH.
//   - in_ready=0 throughout BUSY. in_valid during BUSY is ignored, not queued.
//  Operand capture: a, b and opcode are registered at accept. Later input changes have no effect.
//  Opcode map. Unused high bits are 0. 1-bit results land in res_lo[0].
//   0 |a    1 &a    2 ^a    3 a|b    4 a&b    5 a^b
//   6 a>b   7 a<b   8 (a==0)   9 a==b   F ~a
//   A ADD: res_lo = (a+b) mod 2^WIDTH; res_hi[0] = carry out.
//   B SUB: res_lo = (a-b) mod 2^WIDTH; res_hi[0] = borrow (a<b).
//   C MUL: {res_hi,res_lo} = a*b, full 2*WIDTH-bit product.
//   D SHR: res_lo = a>>b; res_hi=0; b>=WIDTH gives 0.
//   E SHL: {res_hi,res_lo} = {0,a}<<b; b>=2*WIDTH gives 0.
//  zero is computed from the final result and registered together with it.
//  Reset asserted mid-operation (any state) aborts the operation immediately.
//   - The partial product is discarded; all outputs return to reset values.
//  No $display, no X outputs; all 16 opcodes are defined.
// TESTING (WIDTH=8, MUL_SERIAL=1 unless stated)
//  1. Reset release, then ADD a=0xF0 b=0x20 -> one cycle later out_valid=1, res_lo=0x10, res_hi=0x01, zero=0.
//  2. MUL a=0xFF b=0xFF -> in_ready=0 for 8 cycles; then res_hi=0xFE, res_lo=0x01.
//     Repeat with MUL_SERIAL=0 -> same result one cycle after accept.
//  3. Backpressure: SUB a=3 b=5 with out_ready=0 for 4 cycles -> res_lo=0xFE, res_hi=0x01 held stable.
//     Then out_ready=1 together with a new XOR accept -> next result follows with no bubble.
//  4. Shifts: SHL a=0x81 b=1 -> {0x01,0x02}; SHL b=16 -> 0, zero=1; SHR a=0x80 b=9 -> 0.
//  5. Drive rst_n low during cycle 3 of a serial MUL -> out_valid=0 and in_ready=1 after release.
//     A following EQ a=b=7 gives res_lo=1.
//  6. Sweep all 16 opcodes with random a, b against a reference model, including a=0 and b=0 cases.

Source files
------------

// File: rtl/alu_seq_hs.sv
// alu_seq_hs: registered 16-op ALU. Operands and results use valid/ready handshakes.
// Latency: non-MUL ops (and MUL when MUL_SERIAL=0) give a result 1 cycle after accept.
//          With MUL_SERIAL=1, a MUL result arrives WIDTH cycles after accept.
// Backpressure: results hold while out_valid && !out_ready. in_ready drops while BUSY,
//               and also in DONE unless the held result is being taken this cycle.
// Ports:
//   clk, rst_n        clock, asynchronous active-low reset
//   in_valid/in_ready operation handshake; a, b, opcode are captured at accept
//   out_valid/out_ready result handshake; {res_hi,res_lo} result, zero = result==0
module alu_seq_hs #(
  parameter int WIDTH      = 8,
  parameter bit MUL_SERIAL = 1'b1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] res_lo,
  output logic [WIDTH-1:0] res_hi,
  output logic             zero
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t               state;
  logic [2*WIDTH-1:0]   res;     // {res_hi,res_lo}
  logic [2*WIDTH-1:0]   acc;     // running partial product
  logic [2*WIDTH-1:0]   mcand;   // multiplicand, shifted left each step
  logic [WIDTH-1:0]     mplier;  // multiplier, shifted right each step
  logic [CW-1:0]        cnt;
  logic [2*WIDTH-1:0]   res_c;
  logic [2*WIDTH-1:0]   acc_step;
  logic                 accept;
  logic                 take;
  logic                 go_serial;

  assign in_ready  = (state == IDLE) || (state == DONE && out_ready);
  assign accept    = in_valid && in_ready;
  assign take      = out_valid && out_ready;
  assign go_serial = MUL_SERIAL && (opcode == 4'hC);
  assign res_lo    = res[WIDTH-1:0];
  assign res_hi    = res[2*WIDTH-1:WIDTH];

  // Single-cycle result of the presented operands. Bit WIDTH is res_hi[0]
  // (carry for ADD, borrow for SUB).
  always_comb begin
    res_c = '0;
    case (opcode)
      4'h0: res_c[0] = |a;
      4'h1: res_c[0] = &a;
      4'h2: res_c[0] = ^a;
      4'h3: res_c[WIDTH-1:0] = a | b;
      4'h4: res_c[WIDTH-1:0] = a & b;
      4'h5: res_c[WIDTH-1:0] = a ^ b;
      4'h6: res_c[0] = a > b;
      4'h7: res_c[0] = a < b;
      4'h8: res_c[0] = (a == '0);
      4'h9: res_c[0] = (a == b);
      4'hA: res_c[WIDTH:0] = {1'b0, a} + {1'b0, b};
      4'hB: begin
        res_c[WIDTH-1:0] = a - b;
        res_c[WIDTH]     = a < b;
      end
      4'hC: res_c = {{WIDTH{1'b0}}, a} * {{WIDTH{1'b0}}, b};
      4'hD: res_c[WIDTH-1:0] = a >> b;
      4'hE: res_c = {{WIDTH{1'b0}}, a} << b;
      default: res_c[WIDTH-1:0] = ~a;
    endcase
  end

  // One shift-add step: add the multiplicand when the current multiplier LSB is set.
  assign acc_step = mplier[0] ? (acc + mcand) : acc;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      res       <= '0;
      zero      <= 1'b1;
      out_valid <= 1'b0;
      acc       <= '0;
      mcand     <= '0;
      mplier    <= '0;
      cnt       <= '0;
    end else begin
      case (state)
        BUSY: begin
          acc    <= acc_step;
          mcand  <= mcand << 1;
          mplier <= mplier >> 1;
          cnt    <= cnt - CW'(1);
          if (cnt == CW'(1)) begin
            state     <= DONE;
            res       <= acc_step;
            zero      <= (acc_step == '0);
            out_valid <= 1'b1;
          end
        end
        default: begin
          // IDLE and DONE share the accept path; DONE may drain and accept on one edge.
          if (accept) begin
            if (go_serial) begin
              state     <= BUSY;
              acc       <= '0;
              mcand     <= {{WIDTH{1'b0}}, a};
              mplier    <= b;
              cnt       <= CW'(WIDTH);
              out_valid <= 1'b0;
            end else begin
              state     <= DONE;
              res       <= res_c;
              zero      <= (res_c == '0);
              out_valid <= 1'b1;
            end
          end else if (take) begin
            state     <= IDLE;
            out_valid <= 1'b0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_hs.sv
module tb_alu_seq_hs;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] a = '0, b = '0;
  logic [3:0] opcode = '0;
  logic       out_valid;
  logic       out_ready = 1'b1;
  logic [7:0] res_lo, res_hi;
  logic       zero;

  // Parallel-multiply instance
  logic       p_in_valid = 1'b0;
  logic       p_in_ready;
  logic [7:0] p_a = '0, p_b = '0;
  logic [3:0] p_op = '0;
  logic       p_out_valid;
  logic       p_out_ready = 1'b1;
  logic [7:0] p_res_lo, p_res_hi;
  logic       p_zero;

  int checks = 0;
  int errors = 0;
  int mode = 0;             // 0: out_ready=1, 1: random, 2: out_ready=0
  logic [16:0] q[$];        // expected {zero, hi, lo}

  always #5 clk = ~clk;

  alu_seq_hs #(.WIDTH(8), .MUL_SERIAL(1'b1)) u_ser (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .opcode(opcode), .out_valid(out_valid), .out_ready(out_ready),
    .res_lo(res_lo), .res_hi(res_hi), .zero(zero));

  alu_seq_hs #(.WIDTH(8), .MUL_SERIAL(1'b0)) u_par (
    .clk(clk), .rst_n(rst_n), .in_valid(p_in_valid), .in_ready(p_in_ready),
    .a(p_a), .b(p_b), .opcode(p_op), .out_valid(p_out_valid), .out_ready(p_out_ready),
    .res_lo(p_res_lo), .res_hi(p_res_hi), .zero(p_zero));

  // Reference model: plain integer arithmetic on 8-bit operands.
  function automatic logic [16:0] model(input int op, input int x, input int y);
    int r;
    case (op)
      0:  r = (x != 0);
      1:  r = (x == 255);
      2:  r = $countones(x) % 2;
      3:  r = x | y;
      4:  r = x & y;
      5:  r = x ^ y;
      6:  r = (x > y);
      7:  r = (x < y);
      8:  r = (x == 0);
      9:  r = (x == y);
      10: r = x + y;
      11: r = ((x - y) & 255) + ((x < y) ? 256 : 0);
      12: r = x * y;
      13: r = (y >= 8) ? 0 : (x >> y);
      14: r = (y >= 16) ? 0 : ((x << y) & 65535);
      default: r = (~x) & 255;
    endcase
    return {(r == 0), r[15:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Monitor: drives out_ready and compares the presented result with the queue head.
  always @(negedge clk) begin
    out_ready = (mode == 0) ? 1'b1 : (mode == 2) ? 1'b0 : 1'($urandom_range(0, 1));
    if (rst_n && out_valid) begin
      checks++;
      if (q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_result: got hi=%h lo=%h z=%b with nothing expected",
                 res_hi, res_lo, zero);
      end else if ({zero, res_hi, res_lo} !== q[0]) begin
        errors++;
        $display("FAIL result: got z=%b hi=%h lo=%h expected z=%b hi=%h lo=%h",
                 zero, res_hi, res_lo, q[0][16], q[0][15:8], q[0][7:0]);
      end
      if (out_ready && q.size() != 0) void'(q.pop_front());
    end
  end

  task automatic issue(input logic [3:0] op, input logic [7:0] x, input logic [7:0] y);
    int n;
    @(negedge clk);
    in_valid = 1'b1; opcode = op; a = x; b = y;
    #1;
    n = 0;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      chk("issue_timeout", 32'(in_ready), 32'd1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    q.push_back(model(int'(op), int'(x), int'(y)));
    #1 in_valid = 1'b0;
  endtask

  task automatic par_mul(input logic [7:0] x, input logic [7:0] y);
    logic [16:0] e;
    e = model(12, int'(x), int'(y));
    @(negedge clk);
    p_in_valid = 1'b1; p_op = 4'hC; p_a = x; p_b = y;
    #1 chk("par_in_ready", 32'(p_in_ready), 32'd1);
    @(posedge clk);
    #1 p_in_valid = 1'b0;
    chk("par_out_valid", 32'(p_out_valid), 32'd1);
    chk("par_product", {15'd0, p_zero, p_res_hi, p_res_lo}, {15'd0, e});
  endtask

  initial begin
    int n;
    logic busy_ok;
    logic [7:0] x, y;

    // Reset state
    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_res", {16'd0, res_hi, res_lo}, 32'd0);
    chk("rst_zero", 32'(zero), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    #1 chk("rst_in_ready", 32'(in_ready), 32'd1);

    // 1. ADD with carry, one-cycle latency
    issue(4'hA, 8'hF0, 8'h20);
    chk("add_latency", 32'(out_valid), 32'd1);

    // 2. Serial MUL: in_ready low for WIDTH cycles, junk inputs during BUSY ignored
    issue(4'hC, 8'hFF, 8'hFF);
    n = 0; busy_ok = 1'b1;
    while (!out_valid && n < 50) begin
      if (in_ready) busy_ok = 1'b0;
      if (n < 5) begin
        in_valid = 1'b1; opcode = 4'(n); a = 8'($urandom); b = 8'($urandom);
      end else in_valid = 1'b0;
      @(posedge clk); #1; n++;
    end
    in_valid = 1'b0;
    chk("mul_busy_ready_low", 32'(busy_ok), 32'd1);
    chk("mul_latency", n, 32'd8);

    // Parallel multiply: same product, one cycle
    par_mul(8'hFF, 8'hFF);
    par_mul(8'h00, 8'h5A);
    par_mul(8'($urandom), 8'($urandom));

    // 3. Backpressure hold, then drain + accept with no bubble
    issue(4'hB, 8'd3, 8'd5);
    mode = 2;
    repeat (4) @(negedge clk);
    #1 mode = 0;
    @(negedge clk);
    #1 in_valid = 1'b1; opcode = 4'h5; a = 8'h3C; b = 8'hA5;
    chk("drain_accept_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    q.push_back(model(5, 32'h3C, 32'hA5));
    #1 in_valid = 1'b0;
    chk("no_bubble", 32'(out_valid), 32'd1);

    // 4. Shifts
    issue(4'hE, 8'h81, 8'd1);
    issue(4'hE, 8'h81, 8'd16);
    issue(4'hD, 8'h80, 8'd9);
    issue(4'hE, 8'hFF, 8'd15);
    issue(4'hD, 8'hF0, 8'd7);

    // 5. Reset during a serial MUL
    repeat (2) @(negedge clk);
    issue(4'hC, 8'hC3, 8'h7E);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    q.delete();
    #1;
    chk("midrst_out_valid", 32'(out_valid), 32'd0);
    chk("midrst_res", {16'd0, res_hi, res_lo}, 32'd0);
    chk("midrst_zero", 32'(zero), 32'd1);
    @(negedge clk) rst_n = 1'b1;
    #1;
    chk("midrst_in_ready", 32'(in_ready), 32'd1);
    chk("midrst_valid_after", 32'(out_valid), 32'd0);
    issue(4'h9, 8'd7, 8'd7);

    // 6. Random sweep of all opcodes with random backpressure
    mode = 1;
    for (int i = 0; i < 320; i++) begin
      x = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      y = ($urandom_range(0, 4) == 0) ? 8'd0 : 8'($urandom);
      if ((i % 16) >= 13 && $urandom_range(0, 1) == 1) y = 8'($urandom_range(0, 20));
      if ((i % 16) == 9 && $urandom_range(0, 2) == 0) y = x;
      if ((i % 16) == 1 && $urandom_range(0, 2) == 0) x = 8'hFF;
      issue(4'(i % 16), x, y);
    end

    mode = 0;
    n = 0;
    while (q.size() != 0 && n < 100) begin
      @(negedge clk); n++;
    end
    #1 chk("queue_drained", q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
